// File: rtl/s27_bist_driver.sv
// BIST driver for the s27 core: flushes the core state, applies LFSR patterns on
// G0..G3 and compacts the G17 response into a 16-bit MISR signature.
module s27_bist_driver #(
    parameter int unsigned N_PATTERNS   = 64,
    parameter int unsigned FLUSH_CYCLES = 3,
    parameter logic [3:0]  LFSR_SEED    = 4'b0001,
    parameter logic [15:0] MISR_POLY    = 16'h1021,
    parameter logic [15:0] GOLDEN_SIG   = 16'h0000
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    input  logic        abort,
    input  logic        g17_in,
    output logic [3:0]  pat,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] signature
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FLUSH,
        S_RUN,
        S_DONE
    } state_t;

    localparam logic [7:0] FLUSH_LAST = 8'(FLUSH_CYCLES - 1);
    localparam logic [7:0] RUN_LAST   = 8'(N_PATTERNS - 1);
    // Holds G5=0, G6=1, G7=0 in the core after three cycles.
    localparam logic [3:0] PAT_FLUSH  = 4'b1100;

    state_t      state_q, state_d;
    logic [3:0]  pat_q, pat_d;
    logic [3:0]  lfsr_q, lfsr_d;
    logic [15:0] misr_q, misr_d;
    logic [7:0]  cnt_q, cnt_d;

    logic [3:0]  lfsr_step;
    logic [15:0] misr_step;

    assign lfsr_step = {lfsr_q[2:0], lfsr_q[3] ^ lfsr_q[2]};
    assign misr_step = {misr_q[14:0], 1'b0}
                     ^ (misr_q[15] ? MISR_POLY : 16'h0000)
                     ^ {15'b0, g17_in};

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            pat_q   <= 4'b0000;
            lfsr_q  <= LFSR_SEED;
            misr_q  <= 16'h0000;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            lfsr_q  <= lfsr_d;
            misr_q  <= misr_d;
            cnt_q   <= cnt_d;
        end
    end

    // pat_d is the pattern for the state being entered, so pat stays registered.
    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        lfsr_d  = lfsr_q;
        misr_d  = misr_q;
        cnt_d   = cnt_q;
        if (abort) begin
            state_d = S_IDLE;
            pat_d   = 4'b0000;
            misr_d  = 16'h0000;
            cnt_d   = 8'd0;
        end else begin
            unique case (state_q)
                S_IDLE, S_DONE: begin
                    pat_d = 4'b0000;
                    if (start) begin
                        state_d = S_FLUSH;
                        pat_d   = PAT_FLUSH;
                        misr_d  = 16'h0000;
                        cnt_d   = 8'd0;
                    end
                end
                S_FLUSH: begin
                    if (cnt_q == FLUSH_LAST) begin
                        state_d = S_RUN;
                        lfsr_d  = LFSR_SEED;
                        pat_d   = LFSR_SEED;
                        cnt_d   = 8'd0;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
                S_RUN: begin
                    misr_d = misr_step;
                    lfsr_d = lfsr_step;
                    if (cnt_q == RUN_LAST) begin
                        state_d = S_DONE;
                        pat_d   = 4'b0000;
                        cnt_d   = 8'd0;
                    end else begin
                        pat_d = lfsr_step;
                        cnt_d = cnt_q + 8'd1;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    pat_d   = 4'b0000;
                end
            endcase
        end
    end

    assign pat       = pat_q;
    assign busy      = (state_q == S_FLUSH) || (state_q == S_RUN);
    assign done      = (state_q == S_DONE);
    assign pass      = (state_q == S_DONE) && (misr_q == GOLDEN_SIG);
    assign signature = misr_q;

endmodule

// File: tb/tb_s27_bist_driver.sv
// Self-checking bench for s27_bist_driver with a behavioural s27 core as the load.
module tb_s27_bist_driver;

    localparam int NP = 64;
    localparam int FC = 3;

    logic        clock = 1'b0;
    logic        reset_n, start, abort, g17_in;
    logic [3:0]  pat, pat_s;
    logic        busy, done, pass, busy_s, done_s, pass_s;
    logic [15:0] signature, signature_s;

    int   vectors = 0;
    int   miscompares = 0;
    int   g17_mode;
    logic g17_rand;

    logic [3:0] lfsr_seq [15] = '{4'h1, 4'h2, 4'h4, 4'h9, 4'h3, 4'h6, 4'hD, 4'hA,
                                  4'h5, 4'hB, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8};

    always #5 clock = ~clock;

    s27_bist_driver dut (
        .clock(clock), .reset_n(reset_n), .start(start), .abort(abort), .g17_in(g17_in),
        .pat(pat), .busy(busy), .done(done), .pass(pass), .signature(signature)
    );

    s27_bist_driver #(.N_PATTERNS(2), .GOLDEN_SIG(16'h0003)) dut_s (
        .clock(clock), .reset_n(reset_n), .start(start), .abort(abort), .g17_in(g17_in),
        .pat(pat_s), .busy(busy_s), .done(done_s), .pass(pass_s), .signature(signature_s)
    );

    // Behavioural ISCAS s27 core driven by the main DUT's pattern.
    logic g5_q = 1'b1, g6_q = 1'b0, g7_q = 1'b1;
    logic n8, n9, n10, n11, n12, n13, n14, n15, n16, n17;
    always_comb begin
        n14 = ~pat[0];
        n8  = n14 & g6_q;
        n12 = ~(pat[1] | g7_q);
        n15 = n12 | n8;
        n16 = pat[3] | n8;
        n9  = ~(n16 & n15);
        n11 = ~(g5_q | n9);
        n10 = ~(n14 | n11);
        n13 = ~(pat[2] | n12);
        n17 = ~n11;
    end
    always @(posedge clock) begin
        g5_q <= n10;
        g6_q <= n11;
        g7_q <= n13;
    end

    always_comb begin
        case (g17_mode)
            0:       g17_in = 1'b0;
            1:       g17_in = 1'b1;
            2:       g17_in = g17_rand;
            default: g17_in = n17;
        endcase
    end

    function automatic logic [15:0] misr_next(logic [15:0] m, logic g);
        return (m << 1) ^ (m[15] ? 16'h1021 : 16'h0000) ^ {15'b0, g};
    endfunction

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(negedge clock);
        vectors++;
        if ({pat, busy, done, pass, signature} !== 23'h0) begin
            miscompares++;
            $display("FAIL reset_state: got pat=%b busy=%b done=%b pass=%b sig=%h, want all 0",
                     pat, busy, done, pass, signature);
        end
        reset_n = 1'b1;
        g17_mode = 1;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (FC + 5) @(negedge clock);
        vectors++;
        if (busy !== 1'b1 || signature === 16'h0) begin
            miscompares++;
            $display("FAIL reset_prerun: got busy=%b sig=%h, want busy=1 sig!=0", busy, signature);
        end
        #2 reset_n = 1'b0;
        #1;
        vectors++;
        if ({pat, busy, done, pass, signature} !== 23'h0) begin
            miscompares++;
            $display("FAIL reset_async: got pat=%b busy=%b done=%b pass=%b sig=%h, want all 0",
                     pat, busy, done, pass, signature);
        end
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        vectors++;
        if ({pat, busy, done, signature} !== 22'h0) begin
            miscompares++;
            $display("FAIL reset_release: got pat=%b busy=%b done=%b sig=%h, want idle zeros",
                     pat, busy, done, signature);
        end
        $display("reset: async clear mid-run and idle after release checked");
    endtask

    // Full run from IDLE/DONE; checks flush, every RUN pattern and the final signature.
    task automatic test_run(input string name, input int mode, input bit hold,
                            output logic [15:0] sig_out);
        logic [15:0] m;
        logic        g;
        m = 16'h0000;
        g17_mode = mode;
        start = 1'b1;
        @(negedge clock);
        if (!hold) start = 1'b0;
        for (int k = 0; k < FC; k++) begin
            vectors++;
            if ({pat, busy, done} !== {4'b1100, 1'b1, 1'b0}) begin
                miscompares++;
                $display("FAIL %s flush[%0d]: got pat=%b busy=%b done=%b, want pat=1100 busy=1 done=0",
                         name, k, pat, busy, done);
            end
            @(negedge clock);
        end
        for (int k = 0; k < NP; k++) begin
            if (mode == 2) g17_rand = 1'($urandom);
            g = (mode == 2) ? g17_rand : g17_in;
            vectors++;
            if ({pat, busy, done} !== {lfsr_seq[k % 15], 1'b1, 1'b0}) begin
                miscompares++;
                $display("FAIL %s run[%0d]: got pat=%b busy=%b done=%b, want pat=%b busy=1 done=0",
                         name, k, pat, busy, done, lfsr_seq[k % 15]);
            end
            m = misr_next(m, g);
            @(negedge clock);
        end
        start = 1'b0;
        vectors++;
        if ({done, busy, pat, signature, pass} !== {1'b1, 1'b0, 4'h0, m, (m == 16'h0000)}) begin
            miscompares++;
            $display("FAIL %s done: got done=%b busy=%b pat=%b sig=%h pass=%b, want done=1 busy=0 pat=0000 sig=%h pass=%b",
                     name, done, busy, pat, signature, pass, m, (m == 16'h0000));
        end
        $display("%s: signature=%h expected=%h pass=%b", name, signature, m, pass);
        sig_out = signature;
    endtask

    task automatic test_short();
        logic [15:0] m2;
        m2 = misr_next(misr_next(16'h0000, 1'b1), 1'b1);
        g17_mode = 1;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (FC + 1) @(negedge clock);
        vectors++;
        if (done_s !== 1'b0) begin
            miscompares++;
            $display("FAIL short_early: got done=%b one cycle before latency, want 0", done_s);
        end
        @(negedge clock);
        vectors++;
        if ({done_s, busy_s, pat_s, signature_s, pass_s} !== {1'b1, 1'b0, 4'h0, m2, 1'b1}) begin
            miscompares++;
            $display("FAIL short_done: got done=%b busy=%b pat=%b sig=%h pass=%b, want 1 0 0000 %h 1",
                     done_s, busy_s, pat_s, signature_s, pass_s, m2);
        end
        $display("short N=2 g17=1: signature=%h expected=%h", signature_s, m2);
        abort = 1'b1;
        @(negedge clock);
        abort = 1'b0;
        vectors++;
        if ({pat, busy, done, pass, signature} !== 23'h0) begin
            miscompares++;
            $display("FAIL short_abort_main: got pat=%b busy=%b done=%b sig=%h, want idle zeros",
                     pat, busy, done, signature);
        end
    endtask

    task automatic test_abort();
        logic [15:0] s;
        g17_mode = 1;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (FC + 10) @(negedge clock);
        vectors++;
        if ({pat, busy} !== {lfsr_seq[10], 1'b1}) begin
            miscompares++;
            $display("FAIL abort_prerun: got pat=%b busy=%b, want pat=%b busy=1", pat, busy, lfsr_seq[10]);
        end
        abort = 1'b1;
        start = 1'b1;
        @(negedge clock);
        vectors++;
        if ({pat, busy, done, pass, signature} !== 23'h0) begin
            miscompares++;
            $display("FAIL abort_run: got pat=%b busy=%b done=%b pass=%b sig=%h, want all 0",
                     pat, busy, done, pass, signature);
        end
        @(negedge clock);
        vectors++;
        if ({pat, busy} !== 5'h0) begin
            miscompares++;
            $display("FAIL abort_over_start: got pat=%b busy=%b, want idle", pat, busy);
        end
        abort = 1'b0;
        start = 1'b0;
        $display("abort: run cycle 10 aborted, abort held over start");
        test_run("restart_after_abort", 2, 1'b0, s);
    endtask

    task automatic test_back_to_back();
        logic [15:0] s1, s2;
        test_run("s27_run1", 3, 1'b0, s1);
        test_run("s27_run2_start_held", 3, 1'b1, s2);
        vectors++;
        if (s2 !== s1) begin
            miscompares++;
            $display("FAIL back_to_back: got second signature=%h, want first=%h", s2, s1);
        end
    endtask

    initial begin
        logic [15:0] s;
        reset_n  = 1'b0;
        start    = 1'b0;
        abort    = 1'b0;
        g17_mode = 0;
        g17_rand = 1'b0;
        test_reset();
        test_run("zeros_g17", 0, 1'b0, s);
        test_short();
        test_run("random_g17", 2, 1'b0, s);
        test_abort();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
